// File: rtl/baudot_tx.sv
// Asynchronous-frame serial transmitter for 5-bit words: start bit, 5 data bits
// LSB first, then STOP_BITS stop bits. One word per valid/ready handshake.
module baudot_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'd4;
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [BW-1:0] baud, baud_d;
  logic [2:0]    bit_cnt, bit_d;
  logic [4:0]    shift, shift_d;
  logic          serial_d;
  logic          baud_term;

  assign baud_term = (baud == BAUD_LAST);
  assign tx_ready  = (state == IDLE);
  assign tx_busy   = ~tx_ready;

  // Every bit boundary reloads the baud counter; bit_cnt indexes data bits in
  // DATA and stop bits in STOP.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d = state;
    baud_d  = baud + 1'b1;
    bit_d   = bit_cnt;
    shift_d = shift;
    unique case (state)
      IDLE: begin
        baud_d = '0;
        if (tx_valid) begin
          shift_d = tx_data;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_term) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_term) begin
          baud_d  = '0;
          shift_d = shift >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_term) begin
          baud_d = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase

    // The line is decoded from the next state so it changes on the same edge
    // as the state and still comes straight from a flop.
    unique case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      default: serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the shift register is reset with the control state so a word
      // aborted by reset never lingers in the datapath.
      state     <= IDLE;
      baud      <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      tx_serial <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state     <= state_d;
      baud      <= baud_d;
      bit_cnt   <= bit_d;
      shift     <= shift_d;
      tx_serial <= serial_d;
    end
  end

endmodule

// File: tb/tb_baudot_tx.sv
// Self-checking bench for baudot_tx: two instances (4 clk/bit 1 stop, 16 clk/bit
// 2 stops) checked every cycle against a frame-offset model, plus literal pins.
module tb_baudot_tx;

  localparam int NA = 4;
  localparam int SA = 1;
  localparam int NB = 16;
  localparam int SB = 2;
  localparam int LA = (6 + SA) * NA;
  localparam int LB = (6 + SB) * NB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] data_a = '0, data_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, serial_a, busy_a;
  logic       ready_b, serial_b, busy_b;

  int n_cmp  = 0;
  int n_fail = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  baudot_tx #(.CLKS_PER_BIT(NA), .STOP_BITS(SA)) dut_a (
    .clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx_serial(serial_a), .tx_busy(busy_a)
  );

  baudot_tx #(.CLKS_PER_BIT(NB), .STOP_BITS(SB)) dut_b (
    .clk(clk), .rst(rst), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx_serial(serial_b), .tx_busy(busy_b)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected line level at a given cycle offset inside a frame.
  function automatic logic frame_bit(input logic [4:0] d, input int pos, input int n);
    if (pos < n)     return 1'b0;
    if (pos < 6 * n) return d[(pos - n) / n];
    return 1'b1;
  endfunction

  // Model: a frame is just a position counter over a fixed-length waveform.
  logic       ma_busy = 1'b0, mb_busy = 1'b0;
  int         ma_pos = 0, mb_pos = 0;
  logic [4:0] ma_data = '0, mb_data = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma_busy <= 1'b0; ma_pos <= 0; ma_data <= '0;
    end else if (ma_busy) begin
      if (ma_pos == LA - 1) ma_busy <= 1'b0;
      else                  ma_pos  <= ma_pos + 1;
    end else if (valid_a) begin
      ma_busy <= 1'b1; ma_pos <= 0; ma_data <= data_a;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mb_busy <= 1'b0; mb_pos <= 0; mb_data <= '0;
    end else if (mb_busy) begin
      if (mb_pos == LB - 1) mb_busy <= 1'b0;
      else                  mb_pos  <= mb_pos + 1;
    end else if (valid_b) begin
      mb_busy <= 1'b1; mb_pos <= 0; mb_data <= data_b;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("a_serial", int'(serial_a), int'(ma_busy ? frame_bit(ma_data, ma_pos, NA) : 1'b1));
      check("a_ready",  int'(ready_a),  int'(!ma_busy));
      check("a_busy",   int'(busy_a),   int'(ma_busy));
      check("b_serial", int'(serial_b), int'(mb_busy ? frame_bit(mb_data, mb_pos, NB) : 1'b1));
      check("b_ready",  int'(ready_b),  int'(!mb_busy));
      check("b_busy",   int'(busy_b),   int'(mb_busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(ready_a && ready_b) && n < 400) begin
      tick();
      n++;
    end
    check("idle_timeout", int'(ready_a && ready_b), 1);
  endtask

  initial begin
    logic [27:0] vec;
    logic [4:0]  got, got2;
    int cnt, cnt2, start2, prev;

    // Reset with a word pending: nothing may happen until release.
    valid_a = 1'b1; data_a = 5'h1F;
    valid_b = 1'b1; data_b = 5'h1F;
    run_cmp = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_serial", int'(serial_a), 1);
      check("rst_ready",  int'(ready_a), 1);
      check("rst_busy",   int'(busy_a), 0);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    check("rel_no_frame", int'(busy_a), 0);
    @(negedge clk);
    check("rel_first_accept", int'(busy_a), 1);
    check("rel_start_bit", int'(serial_a), 0);
    tick();
    valid_a = 1'b0; valid_b = 1'b0;
    wait_idle();

    // Single frame 5'b10110.
    valid_a = 1'b1; data_a = 5'b10110;
    tick();
    valid_a = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i < 28) vec[27 - i] = serial_a;
      if (busy_a) cnt++;
    end
    check("single_line", int'(vec), int'(28'b0000_0000_1111_1111_0000_1111_1111));
    check("single_busy_len", cnt, 28);
    wait_idle();

    // Back-to-back 5'h00 then 5'h1F with valid held high.
    valid_a = 1'b1; data_a = 5'h00;
    tick();
    data_a = 5'h1F;
    prev = 1; start2 = -1; cnt = 0; got = '0; got2 = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i > 0 && busy_a && prev == 0 && start2 < 0) begin
        start2  = i;
        valid_a = 1'b0;
      end
      if (!busy_a && i <= 40) cnt++;
      for (int k = 0; k < 5; k++) begin
        if (i == NA + NA * k + 2)      got[k]  = serial_a;
        if (i == 29 + NA + NA * k + 2) got2[k] = serial_a;
      end
      prev = int'(busy_a);
    end
    check("b2b_pitch", start2, 29);
    check("b2b_idle_cycles", cnt, 1);
    check("b2b_data0", int'(got), 5'h00);
    check("b2b_data1", int'(got2), 5'h1F);
    wait_idle();

    // Data changes mid-frame must not disturb the frame in flight.
    valid_a = 1'b1; data_a = 5'b00001;
    tick();
    valid_a = 1'b0;
    got = '0;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      if (i == 10) data_a = 5'b11110;
      for (int k = 0; k < 5; k++)
        if (i == NA + NA * k + 2) got[k] = serial_a;
    end
    check("stable_data", int'(got), 5'b00001);
    wait_idle();

    // Two stop bits at 16 clocks per bit.
    valid_b = 1'b1; data_b = 5'h15;
    tick();
    valid_b = 1'b0;
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 131; i++) begin
      @(negedge clk);
      if (busy_b) cnt++;
      if (i >= 96 && i < 128 && serial_b) cnt2++;
    end
    check("stop2_frame_len", cnt, 128);
    check("stop2_high", cnt2, 32);
    wait_idle();

    // Reset during data bit 2, then a clean 5'h0A frame.
    valid_a = 1'b1; data_a = 5'h1B;
    tick();
    valid_a = 1'b0;
    repeat (13) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_serial", int'(serial_a), 1);
    check("midrst_ready",  int'(ready_a), 1);
    check("midrst_busy",   int'(busy_a), 0);
    tick();
    tick();
    rst = 1'b1;
    valid_a = 1'b1; data_a = 5'h0A;
    tick();
    valid_a = 1'b0;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      vec[27 - i] = serial_a;
    end
    check("after_rst_line", int'(vec), int'(28'b0000_0000_1111_0000_1111_0000_1111));
    wait_idle();

    // Random traffic on both instances.
    for (int i = 0; i < 3000; i++) begin
      valid_a = ($urandom_range(3) == 0);
      data_a  = 5'($urandom);
      valid_b = ($urandom_range(3) == 0);
      data_b  = 5'($urandom);
      tick();
    end
    valid_a = 1'b0; valid_b = 1'b0;
    wait_idle();
    @(negedge clk);
    run_cmp = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
